div_ramp_ctrl: RTL
==================

# div_ramp_ctrl

Controller that owns the `count_control` input of the clock divider and slews it from its current value to a requested target in bounded steps. Each intermediate value is held for a fixed dwell time, so the divided clock changes frequency gradually and never jumps. Software or game logic issues a target divisor over a valid/ready handshake. The block reports progress with `busy` and a one-cycle `done`, and supports abort.

## Interface
Parameters:
- `WIDTH`, default 32: width of the divisor, matching `count_control`.
- `DWELL`, default 1000: clk cycles each divisor value is held before the next step (≥1).
- `MIN_DIV`, default 1: lower clamp on any divisor (≥1; the divider computes `count_control-1`).
- `INIT_DIV`, default 25000: divisor driven out of reset (≥`MIN_DIV`).

Ports:
- `clk`, in, 1: single system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `req_valid`, in, 1: new target request.
- `req_ready`, out, 1: high when the block can accept a request.
- `req_div`, in, `WIDTH`: target divisor.
- `req_step`, in, `WIDTH`: maximum change per step; 0 is treated as 1.
- `abort`, in, 1: stop the ramp and freeze at the current value.
- `count_control`, out, `WIDTH`: registered divisor driven to the clock divider.
- `busy`, out, 1: ramp in progress.
- `done`, out, 1: one-cycle pulse when the target is reached.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - RAMP: `req_ready`=0, `busy`=1.
- Accept: a request is accepted on a clk edge where `req_valid && req_ready`. At that edge:
  - Latch target T = max(`req_div`, `MIN_DIV`).
  - Latch step S = (`req_step`==0) ? 1 : `req_step`.
  - Clear the dwell counter.
- If T == `count_control` at accept: stay in IDLE and pulse `done` on the next cycle. `busy` never rises.
- Otherwise, go to RAMP with `busy`=1 from the next cycle.
- In RAMP, the dwell counter increments every cycle. When it reaches `DWELL-1`:
  - Let delta = |T − `count_control`| (unsigned, `WIDTH` bits, computed as larger minus smaller).
  - Move `count_control` toward T by min(S, delta). Overshoot and wrap are impossible.
  - Clear the dwell counter.
  - If the new value equals T: go to IDLE, drop `busy`, and pulse `done` for that one cycle.
- While in RAMP, `req_valid` is ignored. Requests are not queued.
- `abort` in RAMP: go to IDLE at the next edge. `count_control` holds its value, no `done` is issued, and the dwell counter clears.
- `abort` in IDLE is ignored. A simultaneous `req_valid` in IDLE is accepted normally.
- `abort` on the same edge as a step completion: abort wins and the step is not applied.

## Timing
- Reset values: `count_control`=`INIT_DIV`, `busy`=0, `done`=0, `req_ready`=1. State is IDLE and the dwell counter is 0.
- Reset is asynchronous: all outputs take their reset values without waiting for a clk edge.
- `req_ready` is decoded from the state register (high iff IDLE).
- With the accept at edge 0, the k-th step appears at edge k·`DWELL`.
- `done` and the falling edge of `busy` occur on the edge where `count_control` first equals T.
- A new request can be accepted on the cycle `done` is high.
- Total ramp latency is ceil(|T−start|/S)·`DWELL` cycles.

## Structure
- Shared package/header `div_ramp_pkg` holds:
  - State encodings: IDLE=0, RAMP=1.
  - The step-size normalisation constant (minimum step 1).
- Sub-module `dwell_timer`: counter with `clr` and `en` inputs and a `tick` output that is high when the count equals `DWELL-1`. Parameterised by `DWELL`.
- The top level holds the FSM, the target/step registers and the clamped add/subtract.

## Test plan
Bench uses `DWELL`=4, `INIT_DIV`=100, `MIN_DIV`=1.
- Reset asserted with no clk edge → `count_control`=100, `busy`=0, `done`=0, `req_ready`=1 immediately.
- Up ramp, request T=110, S=4 → `count_control` = 104 at +4, 108 at +8, 110 at +12. `done` is high only in cycle +12, where `busy` also falls.
- Down ramp, T=97, S=0 (treated as 1) → 99, 98, 97 at +4, +8, +12, then `done`. Next, request T=0 → clamps to 1 and ramps downward.
- Request T equal to the current value → `done` pulses at +1, `busy` stays 0, `count_control` is unchanged.
- Up ramp as above with `abort` at +6 → IDLE at +7, `count_control` frozen at 104, no `done`. `req_valid` pulsed during RAMP is ignored. A new request is accepted after the abort.
- `rst` asserted mid-ramp at +5 → outputs return to reset values at once. After release, the ramp does not resume.

Source files
------------

// File: rtl/div_ramp_pkg.sv
// Shared types and constants for the divisor ramp controller.
package div_ramp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_t;

    // Smallest step the ramp ever takes; a requested step of 0 becomes this.
    localparam int unsigned MIN_STEP = 1;

endpackage

// File: rtl/div_ramp_ctrl_if.sv
// Request/status bundle between a requester and the divisor ramp controller.
interface div_ramp_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_div;
    logic [WIDTH-1:0] req_step;
    logic             abort;
    logic [WIDTH-1:0] count_control;
    logic             busy;
    logic             done;

    modport master (
        output req_valid, req_div, req_step, abort,
        input  req_ready, count_control, busy, done
    );

    modport slave (
        input  req_valid, req_div, req_step, abort,
        output req_ready, count_control, busy, done
    );
endinterface

// File: rtl/dwell_timer.sv
// Counts the hold time of each divisor value; tick marks the last dwell cycle.
module dwell_timer #(
    parameter int unsigned DWELL = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);
    localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = (r_cnt == CW'(DWELL - 1));

endmodule

// File: rtl/div_ramp_ctrl.sv
// Slews the clock-divider control word toward a requested target in bounded,
// dwell-spaced steps; reports busy and a one-cycle done, and supports abort.
import div_ramp_pkg::*;

module div_ramp_ctrl #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DWELL    = 1000,
    parameter int unsigned MIN_DIV  = 1,
    parameter int unsigned INIT_DIV = 25000
) (
    input logic            clk,
    input logic            rst,
    div_ramp_ctrl_if.slave bus
);
    state_t           r_state;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] r_count;
    logic             r_busy;
    logic             r_done;
    logic             r_eq_pend;

    logic             w_accept;
    logic [WIDTH-1:0] w_req_tgt;
    logic [WIDTH-1:0] w_req_step;
    logic             w_up;
    logic [WIDTH-1:0] w_delta;
    logic [WIDTH-1:0] w_move;
    logic [WIDTH-1:0] w_next;
    logic             w_in_ramp;
    logic             w_abort;
    logic             w_step_now;
    logic             w_tick;

    assign w_in_ramp  = (r_state == RAMP);
    assign w_accept   = bus.req_valid && !w_in_ramp;
    assign w_req_tgt  = (bus.req_div < WIDTH'(MIN_DIV)) ? WIDTH'(MIN_DIV) : bus.req_div;
    assign w_req_step = (bus.req_step == '0) ? WIDTH'(MIN_STEP) : bus.req_step;

    // Move by min(step, distance) so the target is never overshot.
    assign w_up    = (r_target > r_count);
    assign w_delta = w_up ? (r_target - r_count) : (r_count - r_target);
    assign w_move  = (r_step < w_delta) ? r_step : w_delta;
    assign w_next  = w_up ? (r_count + w_move) : (r_count - w_move);

    assign w_abort    = w_in_ramp && bus.abort;
    assign w_step_now = w_in_ramp && w_tick && !bus.abort;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_accept || w_abort || w_step_now),
        .i_en   (w_in_ramp),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_target  <= WIDTH'(INIT_DIV);
            r_step    <= WIDTH'(MIN_STEP);
            r_count   <= WIDTH'(INIT_DIV);
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_eq_pend <= 1'b0;
        end else begin
            // A request that already matches reports done one cycle later.
            r_done    <= r_eq_pend;
            r_eq_pend <= 1'b0;
            if (r_state == IDLE) begin
                if (w_accept) begin
                    r_target <= w_req_tgt;
                    r_step   <= w_req_step;
                    if (w_req_tgt == r_count) begin
                        r_eq_pend <= 1'b1;
                    end else begin
                        r_state <= RAMP;
                        r_busy  <= 1'b1;
                    end
                end
            end else begin
                if (bus.abort) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end else if (w_tick) begin
                    r_count <= w_next;
                    if (w_next == r_target) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.req_ready     = (r_state == IDLE);
    assign bus.count_control = r_count;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;

endmodule
